// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register-file read ports, the
// mul/div engine and the HiLo write path.
interface mul_div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Flush;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic             DivByZero;

   modport master (
      output Start, Op, A, B, Flush,
      input  Busy, Done, Hi, Lo, DivByZero
   );

   modport slave (
      input  Start, Op, A, B, Flush,
      output Busy, Done, Hi, Lo, DivByZero
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative one-bit-per-clock MULT/MULTU/DIV/DIVU engine on sign magnitudes;
// fixed WIDTH+1 cycle latency from accepted Start to the Done pulse.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic            Clk,
   input logic            Reset,
   mul_div_unit_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic               r_is_div, r_neg_lo, r_neg_hi, r_divz;
   logic               r_done, r_dz_out;
   logic [WIDTH-1:0]   r_b, r_a_orig, r_hi, r_lo;
   logic [2*WIDTH-1:0] r_acc;

   logic               w_sgn, w_neg_a, w_neg_b;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b;
   logic [WIDTH:0]     w_sum, w_shl;
   logic [WIDTH+1:0]   w_diff;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_mul_step, w_div_step, w_acc_neg;

   always_comb begin
      w_sgn   = ~bus.Op[0];
      w_neg_a = w_sgn & bus.A[WIDTH-1];
      w_neg_b = w_sgn & bus.B[WIDTH-1];
      w_abs_a = w_neg_a ? -bus.A : bus.A;
      w_abs_b = w_neg_b ? -bus.B : bus.B;
      // mult: {Hi,Lo} holds {partial, multiplier}; add then shift right
      w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
      w_mul_step = {w_sum, r_acc[WIDTH-1:1]};
      // div: {Hi,Lo} holds {remainder, dividend/quotient}; restoring step
      w_shl      = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_diff     = {1'b0, w_shl} - {2'b00, r_b};
      w_ge       = ~w_diff[WIDTH+1];
      w_div_step = {(w_ge ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0]),
                    r_acc[WIDTH-2:0], w_ge};
      w_acc_neg  = -r_acc;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.Start && !bus.Flush) w_state_nxt = S_RUN;
         S_RUN:   if (bus.Flush) w_state_nxt = S_IDLE;
                  else if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_divz   <= 1'b0;
         r_done   <= 1'b0;
         r_dz_out <= 1'b0;
         r_b      <= '0;
         r_a_orig <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_acc    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (bus.Start && !bus.Flush) begin
               r_is_div <= bus.Op[1];
               r_neg_lo <= w_neg_a ^ w_neg_b;
               r_neg_hi <= w_neg_a;
               r_divz   <= bus.Op[1] && (bus.B == '0);
               r_dz_out <= 1'b0;
               r_a_orig <= bus.A;
               r_cnt    <= '0;
               r_b      <= bus.Op[1] ? w_abs_b : w_abs_a;
               r_acc    <= {{WIDTH{1'b0}}, (bus.Op[1] ? w_abs_a : w_abs_b)};
            end
            S_RUN: if (!bus.Flush) begin
               r_acc <= r_is_div ? w_div_step : w_mul_step;
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: if (!bus.Flush) begin
               r_done   <= 1'b1;
               r_dz_out <= r_divz;
               if (r_divz) begin
                  r_hi <= r_a_orig;
                  r_lo <= '1;
               end else if (r_is_div) begin
                  r_lo <= r_neg_lo ? w_acc_neg[WIDTH-1:0] : r_acc[WIDTH-1:0];
                  r_hi <= r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
               end else begin
                  {r_hi, r_lo} <= r_neg_lo ? w_acc_neg : r_acc;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.Busy      = (r_state != S_IDLE);
   assign bus.Done      = r_done;
   assign bus.Hi        = r_hi;
   assign bus.Lo        = r_lo;
   assign bus.DivByZero = r_dz_out;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed checks of mul_div_unit against a plain-arithmetic
// model of MULT/MULTU/DIV/DIVU, including flush, reset and divide-by-zero.
module tb_mul_div_unit;
   localparam int unsigned W = 32;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   mul_div_unit_if #(.WIDTH(W)) bus ();
   mul_div_unit #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint     sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      case (op)
         2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
         default: begin
            if (b == 32'h0) begin
               hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
            end else if (op == 2'b10) begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_hi, e_lo, s_hi;
      logic        e_dz, got_done;
      int          lat, busy_cnt;
      model(op, a, b, e_hi, e_lo, e_dz);
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
      @(posedge Clk); #1;
      bus.Start = 1'b0; bus.Op = ~op; bus.A = $urandom; bus.B = $urandom;
      check("dz_cleared_on_start", {63'h0, bus.DivByZero}, 64'h0);
      lat = 0; busy_cnt = 0; got_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (bus.Done) begin got_done = 1'b1; break; end
         if (bus.Busy) busy_cnt++;
         @(posedge Clk); #1;
         lat++;
      end
      if (!got_done) begin
         check("done_timeout", 64'h0, 64'h1);
      end else begin
         check("latency", 64'(lat), 64'd33);
         check("busy_cycles", 64'(busy_cnt), 64'd33);
         check("busy_at_done", {63'h0, bus.Busy}, 64'h0);
         check("hi", {32'h0, bus.Hi}, {32'h0, e_hi});
         check("lo", {32'h0, bus.Lo}, {32'h0, e_lo});
         check("divbyzero", {63'h0, bus.DivByZero}, {63'h0, e_dz});
         s_hi = bus.Hi;
         @(posedge Clk); #1;
         check("done_pulse", {63'h0, bus.Done}, 64'h0);
         check("hi_hold", {32'h0, bus.Hi}, {32'h0, s_hi});
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corner [6];
      corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
      if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
      return $urandom;
   endfunction

   initial begin
      logic [31:0] p_hi, p_lo;
      logic        saw_done;
      bus.Start = 1'b0; bus.Flush = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
      Reset = 1'b0;
      #23;
      check("rst_busy", {63'h0, bus.Busy}, 64'h0);
      check("rst_done", {63'h0, bus.Done}, 64'h0);
      check("rst_hi", {32'h0, bus.Hi}, 64'h0);
      check("rst_lo", {32'h0, bus.Lo}, 64'h0);
      check("rst_dz", {63'h0, bus.DivByZero}, 64'h0);
      @(negedge Clk); Reset = 1'b1;

      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max_hi", {32'h0, bus.Hi}, 64'hFFFF_FFFE);
      do_op(2'b00, 32'hFFFF_FFFD, 32'd7);
      check("mult_neg_lo", {32'h0, bus.Lo}, 64'hFFFF_FFEB);
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      do_op(2'b11, 32'd7, 32'd2);
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(2'b11, 32'h1234_5678, 32'h0);
      do_op(2'b10, 32'hFFFF_FF00, 32'h0);
      do_op(2'b00, 32'd5, 32'd6);

      // Flush mid-run with an ignored second Start
      p_hi = bus.Hi; p_lo = bus.Lo;
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'd9; bus.B = 32'd9;
      @(posedge Clk); #1; bus.Start = 1'b0;
      repeat (9) @(posedge Clk);
      #1; bus.Start = 1'b1;
      @(posedge Clk); #1; bus.Start = 1'b0;
      repeat (10) @(posedge Clk);
      #1; bus.Flush = 1'b1;
      @(posedge Clk); #1; bus.Flush = 1'b0;
      check("flush_busy", {63'h0, bus.Busy}, 64'h0);
      saw_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.Done || bus.Busy) saw_done = 1'b1;
         @(posedge Clk); #1;
      end
      check("flush_no_done", {63'h0, saw_done}, 64'h0);
      check("flush_hi", {32'h0, bus.Hi}, {32'h0, p_hi});
      check("flush_lo", {32'h0, bus.Lo}, {32'h0, p_lo});

      // Reset mid-divide
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = 2'b10; bus.A = 32'hFFFF_FF9C; bus.B = 32'd7;
      @(posedge Clk); #1; bus.Start = 1'b0;
      repeat (15) @(posedge Clk);
      #1; Reset = 1'b0;
      #1;
      check("midrst_busy", {63'h0, bus.Busy}, 64'h0);
      check("midrst_hi", {32'h0, bus.Hi}, 64'h0);
      check("midrst_lo", {32'h0, bus.Lo}, 64'h0);
      @(negedge Clk); Reset = 1'b1;
      do_op(2'b10, 32'hFFFF_FF9C, 32'd7);

      for (int i = 0; i < 40; i++) begin
         logic [1:0] op;
         op = 2'($urandom_range(3));
         do_op(op, pick(), pick());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
